multibank_arb_ctrl: RTL and testbench
=====================================

Name: multibank_arb_ctrl

Overview:
- Single-clock, two-port banked memory controller.
- Memory split into N_BANKS independent single-access banks; low address bits select the word, high address bits select the bank.
- Ports A and B access different banks concurrently; same-bank collisions are serialised by a round-robin arbiter with valid/ready back-pressure.
- Read data returns through a fixed-latency pipeline per port; sits between the two requesting engines and the banked storage.

Parameters:
- DATA_WIDTH, 8, payload bits per word.
- N_BANKS, 4, number of banks; power of two, >=2.
- BANK_DEPTH, 8, words per bank; power of two, >=2.
- READ_LATENCY, 3, cycles from accepted read to o_rvalid; >=1.
- ADDR_W (localparam), $clog2(N_BANKS*BANK_DEPTH); upper $clog2(N_BANKS) bits = bank, lower bits = word.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_vala / i_valb  in  1  request valid, port A / B
- i_wea / i_web  in  1  1=write, 0=read
- i_addra / i_addrb  in  ADDR_W  address
- i_dina / i_dinb  in  DATA_WIDTH  write data
- o_readya / o_readyb  out  1  request accepted this cycle when valid&ready
- o_douta / o_doutb  out  DATA_WIDTH  read data
- o_rvala / o_rvalb  out  1  read data valid, one-cycle pulse
- o_conflict  out  1  same-bank collision this cycle

Behaviour:
- Reset (async assert, sync release): o_douta/o_doutb=0, o_rvala/o_rvalb=0, read pipelines flushed, priority pointer = A. Bank contents not reset.
- Requests arriving during reset are ignored; reads in flight at reset are lost, with no o_rval pulse.
- Conflict when i_vala & i_valb & bank(A)==bank(B). o_conflict is combinational.
- Arbitration on conflict:
  - Winner = priority pointer; loser's ready=0.
  - Pointer toggles to the loser at that clock edge.
  - Non-conflict cycles leave the pointer unchanged.
- Ready rules:
  - No conflict: both readys=1.
  - Ready is independent of the port's own valid, except for the conflict term.
  - Requester holds valid/addr/data stable until accepted.
- Write accepted at edge T: bank word updated at T.
- Read of same address accepted at T+1 or later returns the new data; write→read ordering across ports follows acceptance order.
- Read accepted at edge T: o_dout valid, o_rval=1 exactly at edge T+READ_LATENCY.
  - Per-port pipeline carries the valid flag; throughput 1 read/cycle/port; in order.
  - o_dout holds its last value when o_rval=0.
- Accepted writes produce no o_rval.
- Ports on different banks proceed fully in parallel, including A write + B read.
- Ports on the same bank but at different word addresses still conflict (single-access banks).
- Address wrap: none needed; all ADDR_W codes are legal because of the power-of-two depth.

Optional Feature:
- Macro MULTIBANK_ECC_EN.
- Defined:
  - Banks store DATA_WIDTH+ECC_BITS bits: Hamming SECDED, 5 check bits for 8 data bits.
  - Writes encode.
  - Reads decode in the last pipeline stage: single-bit error corrected.
  - Extra outputs o_ecc_corra/b (single error corrected) and o_ecc_uncorra/b (double error detected, data passed raw), each valid with o_rval.
  - Latency unchanged.
- Undefined: raw storage, no ECC ports, no check-bit storage.

Decomposition:
- Package multibank_pkg holds:
  - port_e enum {PORT_A, PORT_B} (priority pointer)
  - function ecc_bits(int dw)
  - SECDED encode/syndrome functions
- Sub-module bank_rr_arbiter: pure arbitration plus priority pointer register (inputs: two valids, two bank indices; outputs: readys, conflict).
- Banks and read pipelines stay in the top.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream with 2 reads in flight → all outputs 0, no o_rval after release; pointer=A.
- Parallel access: A writes 0xA5 to addr 0x03 (bank0) while B writes 0x3C to 0x1B (bank3), both ready=1; then reads both → o_douta=0xA5 and o_doutb=0x3C at exactly +3 cycles.
- Conflict fairness: both valid to bank1 (A addr 0x08, B addr 0x0F) for 4 cycles → grants A,B,A,B; o_conflict=1 each cycle; loser holds until accepted.
- Back-to-back: A reads addrs 0..7 on consecutive cycles → 8 consecutive o_rvala pulses, data in order, no bubbles.
- Write-then-read: B writes 0x77 to 0x10 at T, A reads 0x10 at T+1 → o_douta=0x77.
- ECC (macro defined): force single bit flip in stored word → corrected data, o_ecc_corra=1; two flips → o_ecc_uncorra=1.

Source files
------------

// File: rtl/multibank_pkg.sv
// Shared types and SECDED helpers for the banked two-port memory controller.
// ECC helpers are used only when MULTIBANK_ECC_EN is defined.
package multibank_pkg;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  localparam int MAX_DW  = 64;
  localparam int MAX_ECC = 8;
  localparam int MAX_POS = 128;
  localparam int DW_IW   = $clog2(MAX_DW);
  localparam int ECC_IW  = $clog2(MAX_ECC);

  // Hamming check bits plus one overall parity bit
  function automatic int ecc_bits(input int dw);
    int r;
    r = 0;
    for (int k = MAX_ECC - 1; k >= 1; k--)
      if ((1 << k) >= dw + k + 1) r = k;
    return r + 1;
  endfunction

  function automatic logic [MAX_ECC-1:0] secded_encode(input logic [MAX_DW-1:0] data,
                                                       input int dw);
    logic [MAX_ECC-1:0] chk;
    logic               par;
    int                 r;
    int                 di;
    r   = ecc_bits(dw) - 1;
    chk = '0;
    di  = 0;
    // data bits occupy the non-power-of-two codeword positions
    for (int pos = 1; pos < MAX_POS; pos++) begin
      if (di < dw && (pos & (pos - 1)) != 0) begin
        for (int j = 0; j < MAX_ECC - 1; j++)
          if (j < r && ((pos >> j) & 1) == 1)
            chk[ECC_IW'(j)] = chk[ECC_IW'(j)] ^ data[DW_IW'(di)];
        di++;
      end
    end
    par = 1'b0;
    for (int i = 0; i < MAX_DW; i++)
      if (i < dw) par = par ^ data[DW_IW'(i)];
    for (int j = 0; j < MAX_ECC - 1; j++)
      if (j < r) par = par ^ chk[ECC_IW'(j)];
    chk[ECC_IW'(r)] = par;
    return chk;
  endfunction

  // syn[r-1:0] = error position, syn[r] = overall parity mismatch
  function automatic logic [MAX_ECC-1:0] secded_syndrome(input logic [MAX_DW-1:0]  data,
                                                         input logic [MAX_ECC-1:0] chk,
                                                         input int dw);
    logic [MAX_ECC-1:0] calc;
    logic [MAX_ECC-1:0] syn;
    logic               par;
    int                 r;
    r    = ecc_bits(dw) - 1;
    calc = secded_encode(data, dw);
    syn  = '0;
    par  = 1'b0;
    for (int i = 0; i < MAX_DW; i++)
      if (i < dw) par = par ^ data[DW_IW'(i)];
    for (int j = 0; j < MAX_ECC; j++) begin
      if (j <= r) par = par ^ chk[ECC_IW'(j)];
      if (j < r) syn[ECC_IW'(j)] = calc[ECC_IW'(j)] ^ chk[ECC_IW'(j)];
    end
    syn[ECC_IW'(r)] = par;
    return syn;
  endfunction

  function automatic logic [MAX_DW-1:0] secded_correct(input logic [MAX_DW-1:0]  data,
                                                       input logic [MAX_ECC-1:0] syn,
                                                       input int dw);
    logic [MAX_DW-1:0] fixed;
    int                r;
    int                sv;
    int                di;
    r     = ecc_bits(dw) - 1;
    fixed = data;
    sv    = 0;
    di    = 0;
    for (int j = 0; j < MAX_ECC - 1; j++)
      if (j < r && syn[ECC_IW'(j)]) sv = sv | (1 << j);
    if (syn[ECC_IW'(r)]) begin
      for (int pos = 1; pos < MAX_POS; pos++) begin
        if (di < dw && (pos & (pos - 1)) != 0) begin
          if (pos == sv) fixed[DW_IW'(di)] = ~fixed[DW_IW'(di)];
          di++;
        end
      end
    end
    return fixed;
  endfunction

endpackage

// File: rtl/bank_rr_arbiter.sv
// Two-requester round-robin arbiter for single-access banks; the priority
// pointer moves to the losing port whenever a same-bank collision occurs.
module bank_rr_arbiter
  import multibank_pkg::*;
#(
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vala,
  input  logic              valb,
  input  logic [BANK_W-1:0] banka,
  input  logic [BANK_W-1:0] bankb,
  output logic              readya,
  output logic              readyb,
  output logic              conflict
);

  port_e ptr_reg;
  port_e ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= PORT_A;
    else        ptr_reg <= ptr_next;
  end

  always_comb begin
    ptr_next = ptr_reg;
    readya   = 1'b1;
    readyb   = 1'b1;
    conflict = vala & valb & (banka == bankb);
    if (conflict) begin
      if (ptr_reg == PORT_A) begin
        readyb   = 1'b0;
        ptr_next = PORT_B;
      end else begin
        readya   = 1'b0;
        ptr_next = PORT_A;
      end
    end
  end

endmodule

// File: rtl/multibank_arb_ctrl.sv
// Two-port banked memory controller: round-robin on bank collisions, fixed
// latency read pipelines per port. MULTIBANK_ECC_EN adds SECDED storage.
module multibank_arb_ctrl
  import multibank_pkg::*;
#(
  parameter int  DATA_WIDTH   = 8,
  parameter int  N_BANKS      = 4,
  parameter int  BANK_DEPTH   = 8,
  parameter int  READ_LATENCY = 3,
  localparam int ADDR_W       = $clog2(N_BANKS * BANK_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vala,
  input  logic                  i_valb,
  input  logic                  i_wea,
  input  logic                  i_web,
  input  logic [ADDR_W-1:0]     i_addra,
  input  logic [ADDR_W-1:0]     i_addrb,
  input  logic [DATA_WIDTH-1:0] i_dina,
  input  logic [DATA_WIDTH-1:0] i_dinb,
  output logic                  o_readya,
  output logic                  o_readyb,
  output logic [DATA_WIDTH-1:0] o_douta,
  output logic [DATA_WIDTH-1:0] o_doutb,
  output logic                  o_rvala,
  output logic                  o_rvalb,
`ifdef MULTIBANK_ECC_EN
  output logic                  o_ecc_corra,
  output logic                  o_ecc_corrb,
  output logic                  o_ecc_uncorra,
  output logic                  o_ecc_uncorrb,
`endif
  output logic                  o_conflict
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int WORD_W = ADDR_W - BANK_W;
`ifdef MULTIBANK_ECC_EN
  localparam int ECC_BITS = ecc_bits(DATA_WIDTH);
  localparam int MEM_W    = DATA_WIDTH + ECC_BITS;
`else
  localparam int MEM_W    = DATA_WIDTH;
`endif
  localparam int PIPE_W = READ_LATENCY * MEM_W;

  // Requests are ignored until the first edge after reset release
  logic run_reg;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) run_reg <= 1'b0;
    else          run_reg <= 1'b1;
  end

  logic [BANK_W-1:0] bank_a, bank_b;
  logic [WORD_W-1:0] word_a, word_b;
  assign bank_a = i_addra[ADDR_W-1 -: BANK_W];
  assign bank_b = i_addrb[ADDR_W-1 -: BANK_W];
  assign word_a = i_addra[WORD_W-1:0];
  assign word_b = i_addrb[WORD_W-1:0];

  logic arb_ready_a, arb_ready_b;
  bank_rr_arbiter #(.BANK_W(BANK_W)) u_arb (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .vala     (i_vala & run_reg),
    .valb     (i_valb & run_reg),
    .banka    (bank_a),
    .bankb    (bank_b),
    .readya   (arb_ready_a),
    .readyb   (arb_ready_b),
    .conflict (o_conflict)
  );

  assign o_readya = arb_ready_a & run_reg;
  assign o_readyb = arb_ready_b & run_reg;

  logic acc_a, acc_b;
  assign acc_a = i_vala & o_readya;
  assign acc_b = i_valb & o_readyb;

  logic [MEM_W-1:0] wdata_a, wdata_b;
`ifdef MULTIBANK_ECC_EN
  logic [MAX_ECC-1:0] chk_a, chk_b;
  assign chk_a   = secded_encode(MAX_DW'(i_dina), DATA_WIDTH);
  assign chk_b   = secded_encode(MAX_DW'(i_dinb), DATA_WIDTH);
  assign wdata_a = {chk_a[ECC_BITS-1:0], i_dina};
  assign wdata_b = {chk_b[ECC_BITS-1:0], i_dinb};
`else
  assign wdata_a = i_dina;
  assign wdata_b = i_dinb;
`endif

  logic [MEM_W-1:0] bank_rd_a [N_BANKS];
  logic [MEM_W-1:0] bank_rd_b [N_BANKS];

  genvar gi;
  generate
    for (gi = 0; gi < N_BANKS; gi++) begin : g_bank
      logic [MEM_W-1:0]  mem_reg [BANK_DEPTH];
      logic              we;
      logic [WORD_W-1:0] waddr;
      logic [MEM_W-1:0]  wdata;

      // The arbiter guarantees at most one accepted port per bank
      always_comb begin
        we    = 1'b0;
        waddr = word_a;
        wdata = wdata_a;
        if (acc_a && i_wea && bank_a == BANK_W'(gi)) begin
          we = 1'b1;
        end else if (acc_b && i_web && bank_b == BANK_W'(gi)) begin
          we    = 1'b1;
          waddr = word_b;
          wdata = wdata_b;
        end
      end

      always_ff @(posedge i_clk) begin
        if (we) mem_reg[waddr] <= wdata;
      end

      assign bank_rd_a[gi] = mem_reg[word_a];
      assign bank_rd_b[gi] = mem_reg[word_b];
    end
  endgenerate

  logic                  port_acc_rd [2];
  logic [MEM_W-1:0]      port_rd     [2];
  logic [DATA_WIDTH-1:0] port_dout   [2];
  logic                  port_rval   [2];
  assign port_acc_rd[0] = acc_a & ~i_wea;
  assign port_acc_rd[1] = acc_b & ~i_web;
  assign port_rd[0]     = bank_rd_a[bank_a];
  assign port_rd[1]     = bank_rd_b[bank_b];

`ifdef MULTIBANK_ECC_EN
  logic port_corr   [2];
  logic port_uncorr [2];
`endif

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [READ_LATENCY-1:0]            vld_reg;
      logic [READ_LATENCY-1:0][MEM_W-1:0] dat_reg;
      logic [MEM_W-1:0]                   last_word;
      logic [DATA_WIDTH-1:0]              rd_word;
      logic [DATA_WIDTH-1:0]              dout_reg;
      logic                               rval_reg;

      assign last_word = dat_reg[READ_LATENCY-1];

`ifdef MULTIBANK_ECC_EN
      logic [MAX_ECC-1:0] syn;
      logic [MAX_DW-1:0]  fixed;
      logic               err_single, err_double;
      logic               corr_reg, uncorr_reg;

      always_comb begin
        syn   = secded_syndrome(MAX_DW'(last_word[DATA_WIDTH-1:0]),
                                MAX_ECC'(last_word[MEM_W-1:DATA_WIDTH]), DATA_WIDTH);
        fixed = secded_correct(MAX_DW'(last_word[DATA_WIDTH-1:0]), syn, DATA_WIDTH);
      end
      assign err_single = syn[ECC_BITS-1];
      assign err_double = ~syn[ECC_BITS-1] & (syn[ECC_BITS-2:0] != '0);
      assign rd_word    = fixed[DATA_WIDTH-1:0];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          corr_reg   <= 1'b0;
          uncorr_reg <= 1'b0;
        end else begin
          corr_reg   <= vld_reg[READ_LATENCY-1] & err_single;
          uncorr_reg <= vld_reg[READ_LATENCY-1] & err_double;
        end
      end
      assign port_corr[gi]   = corr_reg;
      assign port_uncorr[gi] = uncorr_reg;
`else
      assign rd_word = last_word;
`endif

      // Stage 0 captures the bank word at the accepting edge
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          vld_reg  <= '0;
          dat_reg  <= '0;
          rval_reg <= 1'b0;
          dout_reg <= '0;
        end else begin
          vld_reg  <= READ_LATENCY'({vld_reg, port_acc_rd[gi]});
          dat_reg  <= PIPE_W'({dat_reg, port_rd[gi]});
          rval_reg <= vld_reg[READ_LATENCY-1];
          if (vld_reg[READ_LATENCY-1]) dout_reg <= rd_word;
        end
      end

      assign port_dout[gi] = dout_reg;
      assign port_rval[gi] = rval_reg;
    end
  endgenerate

  assign o_douta = port_dout[0];
  assign o_doutb = port_dout[1];
  assign o_rvala = port_rval[0];
  assign o_rvalb = port_rval[1];
`ifdef MULTIBANK_ECC_EN
  assign o_ecc_corra   = port_corr[0];
  assign o_ecc_corrb   = port_corr[1];
  assign o_ecc_uncorra = port_uncorr[0];
  assign o_ecc_uncorrb = port_uncorr[1];
`endif

endmodule

// File: tb/tb_multibank_arb_ctrl.sv
// Directed bench for multibank_arb_ctrl; ECC scenario compiled only with
// MULTIBANK_ECC_EN.
module tb_multibank_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vala, valb, wea, web;
  logic [4:0] addra, addrb;
  logic [7:0] dina, dinb;
  logic       readya, readyb, rvala, rvalb, conflict;
  logic [7:0] douta, doutb;
`ifdef MULTIBANK_ECC_EN
  logic       corra, corrb, uncorra, uncorrb;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multibank_arb_ctrl #(
    .DATA_WIDTH(8), .N_BANKS(4), .BANK_DEPTH(8), .READ_LATENCY(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_vala(vala), .i_valb(valb), .i_wea(wea), .i_web(web),
    .i_addra(addra), .i_addrb(addrb), .i_dina(dina), .i_dinb(dinb),
    .o_readya(readya), .o_readyb(readyb),
    .o_douta(douta), .o_doutb(doutb),
    .o_rvala(rvala), .o_rvalb(rvalb),
`ifdef MULTIBANK_ECC_EN
    .o_ecc_corra(corra), .o_ecc_corrb(corrb),
    .o_ecc_uncorra(uncorra), .o_ecc_uncorrb(uncorrb),
`endif
    .o_conflict(conflict)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vala = 1'b0; valb = 1'b0; wea = 1'b0; web = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); addra = '0; addrb = '0; dina = '0; dinb = '0;
    repeat (3) tick();
    checks++; if (douta !== 8'h00) begin failures++; $display("FAIL rst_douta got=%h exp=00", douta); end
    checks++; if (doutb !== 8'h00) begin failures++; $display("FAIL rst_doutb got=%h exp=00", doutb); end
    checks++; if (rvala !== 1'b0) begin failures++; $display("FAIL rst_rvala got=%b exp=0", rvala); end
    checks++; if (rvalb !== 1'b0) begin failures++; $display("FAIL rst_rvalb got=%b exp=0", rvalb); end
    rst_n = 1'b1;
    repeat (2) tick();
    // pointer starts at A: on a collision A is granted
    vala = 1'b1; valb = 1'b1; addra = 5'h08; addrb = 5'h0F; #1;
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL rst_ptr_conflict got=%b exp=1", conflict); end
    checks++; if ({readya, readyb} !== 2'b10) begin failures++; $display("FAIL rst_ptr_ready got=%b exp=10", {readya, readyb}); end
    idle();
    tick();
    $display("txn reset: initial reset and pointer check done");
  endtask

  task automatic test_parallel();
    vala = 1'b1; wea = 1'b1; addra = 5'h03; dina = 8'hA5;
    valb = 1'b1; web = 1'b1; addrb = 5'h1B; dinb = 8'h3C; #1;
    checks++; if ({readya, readyb, conflict} !== 3'b110) begin failures++; $display("FAIL par_wr_ready got=%b exp=110", {readya, readyb, conflict}); end
    tick();
    $display("txn parallel: A wr 03=a5, B wr 1b=3c");
    wea = 1'b0; web = 1'b0; #1;
    checks++; if ({readya, readyb} !== 2'b11) begin failures++; $display("FAIL par_rd_ready got=%b exp=11", {readya, readyb}); end
    tick();
    $display("txn parallel: A rd 03, B rd 1b");
    idle();
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 3) begin
        checks++; if ({rvala, rvalb} !== 2'b00) begin failures++; $display("FAIL par_early_rval cyc=%0d got=%b exp=00", c, {rvala, rvalb}); end
      end else if (c == 3) begin
        checks++; if ({rvala, rvalb} !== 2'b11) begin failures++; $display("FAIL par_rval got=%b exp=11", {rvala, rvalb}); end
        checks++; if (douta !== 8'hA5) begin failures++; $display("FAIL par_douta got=%h exp=a5", douta); end
        checks++; if (doutb !== 8'h3C) begin failures++; $display("FAIL par_doutb got=%h exp=3c", doutb); end
      end else begin
        checks++; if ({rvala, rvalb} !== 2'b00) begin failures++; $display("FAIL par_pulse_width got=%b exp=00", {rvala, rvalb}); end
        checks++; if (douta !== 8'hA5) begin failures++; $display("FAIL par_dout_hold got=%h exp=a5", douta); end
      end
    end
  endtask

  task automatic test_reset_inflight();
    // collision: A wins, pointer moves to B
    vala = 1'b1; wea = 1'b0; addra = 5'h03;
    valb = 1'b1; web = 1'b0; addrb = 5'h04; #1;
    checks++; if ({readya, readyb} !== 2'b10) begin failures++; $display("FAIL rsti_ready got=%b exp=10", {readya, readyb}); end
    tick();
    valb = 1'b0;
    tick();
    idle();
    rst_n = 1'b0; #1;
    $display("txn reset: asserted with 2 reads in flight");
    checks++; if (douta !== 8'h00) begin failures++; $display("FAIL rsti_douta got=%h exp=00", douta); end
    checks++; if (doutb !== 8'h00) begin failures++; $display("FAIL rsti_doutb got=%h exp=00", doutb); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if ({rvala, rvalb} !== 2'b00) begin failures++; $display("FAIL rsti_no_rval cyc=%0d got=%b exp=00", c, {rvala, rvalb}); end
    end
    vala = 1'b1; valb = 1'b1; addra = 5'h08; addrb = 5'h0F; #1;
    checks++; if ({readya, readyb} !== 2'b10) begin failures++; $display("FAIL rsti_ptr got=%b exp=10", {readya, readyb}); end
    idle();
    tick();
  endtask

  task automatic test_conflict();
    logic [7:0] a_tab  [4] = '{8'h11, 8'h33, 8'h33, 8'h55};
    logic [7:0] b_tab  [4] = '{8'h22, 8'h22, 8'h44, 8'h44};
    logic [1:0] rd_tab [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    for (int c = 0; c < 4; c++) begin
      vala = 1'b1; wea = 1'b1; addra = 5'h08; dina = a_tab[c];
      valb = 1'b1; web = 1'b1; addrb = 5'h0F; dinb = b_tab[c]; #1;
      checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL cfl_conflict cyc=%0d got=%b exp=1", c, conflict); end
      checks++; if ({readya, readyb} !== rd_tab[c]) begin failures++; $display("FAIL cfl_grant cyc=%0d got=%b exp=%b", c, {readya, readyb}, rd_tab[c]); end
      tick();
      $display("txn conflict cyc=%0d: A wr 08=%h, B wr 0f=%h", c, a_tab[c], b_tab[c]);
    end
    idle();
    vala = 1'b1; addra = 5'h08; tick();
    addra = 5'h0F; tick();
    idle();
    tick();
    checks++; if (rvala !== 1'b0) begin failures++; $display("FAIL cfl_rd_early got=%b exp=0", rvala); end
    tick();
    checks++; if ({rvala, douta} !== {1'b1, 8'h33}) begin failures++; $display("FAIL cfl_rd0 got=%b/%h exp=1/33", rvala, douta); end
    tick();
    checks++; if ({rvala, douta} !== {1'b1, 8'h44}) begin failures++; $display("FAIL cfl_rd1 got=%b/%h exp=1/44", rvala, douta); end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      valb = 1'b1; web = 1'b1; addrb = 5'(i); dinb = 8'h40 + 8'(i);
      tick();
    end
    idle();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        vala = 1'b1; wea = 1'b0; addra = 5'(c); #1;
        checks++; if (readya !== 1'b1) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", c, readya); end
      end else begin
        idle();
      end
      tick();
      if (c >= 3 && c < 11) begin
        exp_d = 8'h40 + 8'(c - 3);
        checks++; if ({rvala, douta} !== {1'b1, exp_d}) begin failures++; $display("FAIL b2b_data idx=%0d got=%b/%h exp=1/%h", c - 3, rvala, douta, exp_d); end
        $display("txn b2b: A rd %h -> %h", 5'(c - 3), douta);
      end else begin
        checks++; if ({rvala, rvalb} !== 2'b00) begin failures++; $display("FAIL b2b_idle cyc=%0d got=%b exp=00", c, {rvala, rvalb}); end
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_write_then_read();
    vala = 1'b1; wea = 1'b1; addra = 5'h18; dina = 8'h5A;
    valb = 1'b1; web = 1'b1; addrb = 5'h10; dinb = 8'h77; #1;
    checks++; if ({readya, readyb, conflict} !== 3'b110) begin failures++; $display("FAIL wtr_wr_ready got=%b exp=110", {readya, readyb, conflict}); end
    tick();
    wea = 1'b0; addra = 5'h10; web = 1'b0; addrb = 5'h18;
    tick();
    idle();
    repeat (3) tick();
    checks++; if ({rvala, douta} !== {1'b1, 8'h77}) begin failures++; $display("FAIL wtr_douta got=%b/%h exp=1/77", rvala, douta); end
    checks++; if ({rvalb, doutb} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL wtr_doutb got=%b/%h exp=1/5a", rvalb, doutb); end
    $display("txn write_then_read: A rd 10 -> %h, B rd 18 -> %h", douta, doutb);
    // A write and B read in parallel on different banks
    vala = 1'b1; wea = 1'b1; addra = 5'h00; dina = 8'h99;
    valb = 1'b1; web = 1'b0; addrb = 5'h10; #1;
    checks++; if ({readya, readyb} !== 2'b11) begin failures++; $display("FAIL wtr_mix_ready got=%b exp=11", {readya, readyb}); end
    tick();
    idle();
    repeat (3) tick();
    checks++; if ({rvala, rvalb, doutb} !== {1'b0, 1'b1, 8'h77}) begin failures++; $display("FAIL wtr_mix got=%b%b/%h exp=01/77", rvala, rvalb, doutb); end
    tick();
  endtask

`ifdef MULTIBANK_ECC_EN
  task automatic test_ecc();
    vala = 1'b1; wea = 1'b1; addra = 5'h10; dina = 8'h96; tick();
    idle();
    dut.g_bank[2].mem_reg[0] = dut.g_bank[2].mem_reg[0] ^ 13'h002;
    vala = 1'b1; addra = 5'h10; tick();
    idle();
    repeat (3) tick();
    checks++; if ({rvala, douta} !== {1'b1, 8'h96}) begin failures++; $display("FAIL ecc_single_data got=%b/%h exp=1/96", rvala, douta); end
    checks++; if ({corra, uncorra} !== 2'b10) begin failures++; $display("FAIL ecc_single_flags got=%b exp=10", {corra, uncorra}); end
    dut.g_bank[2].mem_reg[0] = dut.g_bank[2].mem_reg[0] ^ 13'h004;
    vala = 1'b1; addra = 5'h10; tick();
    idle();
    repeat (3) tick();
    checks++; if ({rvala, douta} !== {1'b1, 8'h90}) begin failures++; $display("FAIL ecc_double_data got=%b/%h exp=1/90", rvala, douta); end
    checks++; if ({corra, uncorra} !== 2'b01) begin failures++; $display("FAIL ecc_double_flags got=%b exp=01", {corra, uncorra}); end
    $display("txn ecc: single and double flip reads done");
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_parallel();
    test_reset_inflight();
    test_conflict();
    test_back_to_back();
    test_write_then_read();
`ifdef MULTIBANK_ECC_EN
    test_ecc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
